// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of the single main-memory port.
// Port 0 is the I-cache, port 1 the D-cache. A grant covers one whole line
// (WORDS_PER_LINE fulfilled beats) and then passes round-robin. Once a port
// owns memory, the request and response paths are purely combinational.
// Optional feature: define MEM_ARBITER_STATS_EN to add the grants0, grants1
// and conflicts counters.
module mem_arbiter #(
   parameter int XLEN      = 32,
   parameter int LINE_SIZE = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid,
   input  logic            req0_write,
   input  logic [XLEN-1:0] req0_address,
   input  logic [XLEN-1:0] req0_store_word,
   output logic [XLEN-1:0] req0_loaded_word,
   output logic            req0_fulfilled,
   input  logic            req1_valid,
   input  logic            req1_write,
   input  logic [XLEN-1:0] req1_address,
   input  logic [XLEN-1:0] req1_store_word,
   output logic [XLEN-1:0] req1_loaded_word,
   output logic            req1_fulfilled,
   output logic            mem_valid,
   output logic            mem_write,
   output logic [XLEN-1:0] mem_address,
   output logic [XLEN-1:0] mem_store_word,
   input  logic [XLEN-1:0] mem_loaded_word,
   input  logic            mem_fulfilled
`ifdef MEM_ARBITER_STATS_EN
   ,
   output logic [XLEN-1:0] grants0,
   output logic [XLEN-1:0] grants1,
   output logic [XLEN-1:0] conflicts
`endif
);

   localparam int WORDS_PER_LINE = LINE_SIZE / 4;
   localparam int BEAT_W         = $clog2(WORDS_PER_LINE);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [BEAT_W-1:0] beats_reg, beats_next;
   // Requester favoured when both ask in the same IDLE cycle.
   logic              prio_reg, prio_next;

   // State, beat counter and round-robin bit; reset abandons any line in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         beats_reg <= '0;
         prio_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         beats_reg <= beats_next;
         prio_reg  <= prio_next;
      end
   end

   // Arbitration in IDLE; while owning, count fulfilled beats and release on the last one.
   always_comb begin
      state_next = state_reg;
      beats_next = beats_reg;
      prio_next  = prio_reg;
      case (state_reg)
         IDLE: begin
            // mem_fulfilled is deliberately ignored here: no owner, no beat.
            if (req0_valid && req1_valid)
               state_next = prio_reg ? OWN1 : OWN0;
            else if (req0_valid)
               state_next = OWN0;
            else if (req1_valid)
               state_next = OWN1;
         end
         OWN0, OWN1: begin
            // The owner dropping valid does not release; only a complete line does.
            if (mem_fulfilled) begin
               if (beats_reg == LAST_BEAT) begin
                  state_next = IDLE;
                  beats_next = '0;
                  prio_next  = (state_reg == OWN0);
               end else begin
                  beats_next = beats_reg + BEAT_W'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
            beats_next = '0;
         end
      endcase
   end

   // Steer the owner's request to memory and the memory response back to the owner only.
   always_comb begin
      mem_valid        = 1'b0;
      mem_write        = 1'b0;
      mem_address      = '0;
      mem_store_word   = '0;
      req0_loaded_word = '0;
      req0_fulfilled   = 1'b0;
      req1_loaded_word = '0;
      req1_fulfilled   = 1'b0;
      case (state_reg)
         OWN0: begin
            mem_valid        = req0_valid;
            mem_write        = req0_write;
            mem_address      = req0_address;
            mem_store_word   = req0_store_word;
            req0_loaded_word = mem_loaded_word;
            req0_fulfilled   = mem_fulfilled;
         end
         OWN1: begin
            mem_valid        = req1_valid;
            mem_write        = req1_write;
            mem_address      = req1_address;
            mem_store_word   = req1_store_word;
            req1_loaded_word = mem_loaded_word;
            req1_fulfilled   = mem_fulfilled;
         end
         default: begin
         end
      endcase
   end

`ifdef MEM_ARBITER_STATS_EN
   logic grant0_evt, grant1_evt, conflict_evt;

   assign grant0_evt   = (state_reg == IDLE) && (state_next == OWN0);
   assign grant1_evt   = (state_reg == IDLE) && (state_next == OWN1);
   assign conflict_evt = (state_reg == IDLE) && req0_valid && req1_valid;

   // Free-running statistics counters; they wrap naturally at 2^XLEN.
   always_ff @(posedge clk) begin
      if (reset) begin
         grants0   <= '0;
         grants1   <= '0;
         conflicts <= '0;
      end else begin
         if (grant0_evt)   grants0   <= grants0 + XLEN'(1);
         if (grant1_evt)   grants1   <= grants1 + XLEN'(1);
         if (conflict_evt) conflicts <= conflicts + XLEN'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter (8 words per line).
// A behavioural model (owner / beat count / favoured port) predicts every
// output each cycle; a vector table and hand-written sequences cover the
// line-fill, tie, write, gap and reset-mid-line cases; random stimulus follows.
module tb_mem_arbiter;

   localparam int XLEN = 32;
   localparam int W    = 8;

   logic            clk, rst;
   logic            v0, w0, v1, w1;
   logic [XLEN-1:0] a0, d0, a1, d1, mld;
   logic            mful;
   logic [XLEN-1:0] ld0, ld1, ma, md;
   logic            f0, f1, mv, mw;
`ifdef MEM_ARBITER_STATS_EN
   logic [XLEN-1:0] g0, g1, cf;
   logic [XLEN-1:0] m_g0, m_g1, m_cf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Model: owner is -1 when nobody holds memory.
   int m_owner, m_beats, m_prio;

   mem_arbiter #(.XLEN(XLEN), .LINE_SIZE(32)) dut (
      .clk(clk), .reset(rst),
      .req0_valid(v0), .req0_write(w0), .req0_address(a0), .req0_store_word(d0),
      .req0_loaded_word(ld0), .req0_fulfilled(f0),
      .req1_valid(v1), .req1_write(w1), .req1_address(a1), .req1_store_word(d1),
      .req1_loaded_word(ld1), .req1_fulfilled(f1),
      .mem_valid(mv), .mem_write(mw), .mem_address(ma), .mem_store_word(md),
      .mem_loaded_word(mld), .mem_fulfilled(mful)
`ifdef MEM_ARBITER_STATS_EN
      , .grants0(g0), .grants1(g1), .conflicts(cf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
      end
   endtask

   // Compare every output against the model's view of the current cycle.
   task automatic check_model(input string name);
      logic e_mv, e_mw, e_f0, e_f1;
      logic [XLEN-1:0] e_ma, e_md, e_ld0, e_ld1;
      e_mv = 0; e_mw = 0; e_f0 = 0; e_f1 = 0;
      e_ma = '0; e_md = '0; e_ld0 = '0; e_ld1 = '0;
      if (m_owner == 0) begin
         e_mv = v0; e_mw = w0; e_ma = a0; e_md = d0; e_ld0 = mld; e_f0 = mful;
      end else if (m_owner == 1) begin
         e_mv = v1; e_mw = w1; e_ma = a1; e_md = d1; e_ld1 = mld; e_f1 = mful;
      end
      n_tests++;
      if ({mv, mw, ma, md, f0, f1, ld0, ld1} !== {e_mv, e_mw, e_ma, e_md, e_f0, e_f1, e_ld0, e_ld1}) begin
         n_fail++;
         $display("FAIL %s t=%0t got mv=%b mw=%b ma=%h md=%h f0=%b f1=%b ld0=%h ld1=%h expected mv=%b mw=%b ma=%h md=%h f0=%b f1=%b ld0=%h ld1=%h",
                  name, $time, mv, mw, ma, md, f0, f1, ld0, ld1,
                  e_mv, e_mw, e_ma, e_md, e_f0, e_f1, e_ld0, e_ld1);
      end
`ifdef MEM_ARBITER_STATS_EN
      check({name, "_grants0"}, g0, m_g0);
      check({name, "_grants1"}, g1, m_g1);
      check({name, "_conflicts"}, cf, m_cf);
`endif
   endtask

   task automatic cyc_check(input string name);
      #4;
      check_model(name);
   endtask

   // Clock edge: update the model from the inputs held across the edge.
   task automatic advance();
      @(posedge clk);
      if (rst) begin
         m_owner = -1; m_beats = 0; m_prio = 0;
`ifdef MEM_ARBITER_STATS_EN
         m_g0 = 0; m_g1 = 0; m_cf = 0;
`endif
      end else if (m_owner < 0) begin
`ifdef MEM_ARBITER_STATS_EN
         if (v0 && v1) m_cf = m_cf + 1;
`endif
         if (v0 && v1) m_owner = m_prio;
         else if (v0)  m_owner = 0;
         else if (v1)  m_owner = 1;
`ifdef MEM_ARBITER_STATS_EN
         if (m_owner == 0) m_g0 = m_g0 + 1;
         if (m_owner == 1) m_g1 = m_g1 + 1;
`endif
      end else if (mful) begin
         if (m_beats == W - 1) begin
            m_prio  = 1 - m_owner;
            m_owner = -1;
            m_beats = 0;
         end else begin
            m_beats++;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      v0 = 0; w0 = 0; a0 = '0; d0 = '0;
      v1 = 0; w1 = 0; a1 = '0; d1 = '0;
      mld = '0; mful = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      cyc_check("reset_cycle");
      advance();
      rst = 0;
   endtask

   typedef struct {
      logic            v1;
      logic [XLEN-1:0] a1;
      logic [XLEN-1:0] mld;
      logic            mful;
      logic            e_mv;
      logic [XLEN-1:0] e_ma;
      logic            e_f1;
      logic [XLEN-1:0] e_ld1;
   } vec_t;

   vec_t tbl[11];
   int   cq[$];
   int   pq[$];

   initial begin
      int n0, n1, idx, gap_left, gap_done, fcount;
      logic last_f1;

      // Vector table: req1 line fill at 0x1000 returning 0xA0..0xA7.
      tbl[0] = '{1'b0, 32'h0,    32'h55,   1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 32'h1000, 32'hDEAD, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
      for (int i = 0; i < 8; i++)
         tbl[2+i] = '{1'b1, 32'(32'h1000 + 4*i), 32'(32'hA0 + i), 1'b1,
                      1'b1, 32'(32'h1000 + 4*i), 1'b1, 32'(32'hA0 + i)};
      tbl[10] = '{1'b0, 32'h1000, 32'h77, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};

      // Power-up reset: model is not yet in sync, so nothing is checked here.
      idle_inputs();
      rst = 1;
      m_owner = -1; m_beats = 0; m_prio = 0;
`ifdef MEM_ARBITER_STATS_EN
      m_g0 = 0; m_g1 = 0; m_cf = 0;
`endif
      @(posedge clk); #1;
      advance();
      rst = 0;

      for (int i = 0; i < 11; i++) begin
         idle_inputs();
         a0 = 32'h300;
         v1 = tbl[i].v1; a1 = tbl[i].a1; mld = tbl[i].mld; mful = tbl[i].mful;
         #4;
         n_tests++;
         if ({mv, mw, ma, md, f0, ld0, f1, ld1} !==
             {tbl[i].e_mv, 1'b0, tbl[i].e_ma, 32'h0, 1'b0, 32'h0, tbl[i].e_f1, tbl[i].e_ld1}) begin
            n_fail++;
            $display("FAIL vec%0d got mv=%b mw=%b ma=%h md=%h f0=%b ld0=%h f1=%b ld1=%h expected mv=%b mw=0 ma=%h md=0 f0=0 ld0=0 f1=%b ld1=%h",
                     i, mv, mw, ma, md, f0, ld0, f1, ld1,
                     tbl[i].e_mv, tbl[i].e_ma, tbl[i].e_f1, tbl[i].e_ld1);
         end
         check_model("vec_model");
         advance();
      end

      // Tie after reset: req0 first, req1 two cycles after req0's last beat, then req0 again.
      do_reset();
      for (int c = 0; c < 30; c++) begin
         v0 = 1; a0 = 32'h100; v1 = 1; a1 = 32'h200;
         mful = 1; mld = 32'(c);
         cyc_check("tie");
         if (f0) begin cq.push_back(c); pq.push_back(0); end
         if (f1) begin cq.push_back(c); pq.push_back(1); end
         advance();
      end
      check("tie_beats", 32'(cq.size() >= 24), 32'd1);
      if (cq.size() >= 24) begin
         for (int i = 0; i < 24; i++)
            check("tie_owner", 32'(pq[i]), (i >= 8 && i < 16) ? 32'd1 : 32'd0);
         check("tie_gap1", 32'(cq[8] - cq[7]), 32'd2);
         check("tie_gap2", 32'(cq[16] - cq[15]), 32'd2);
         check("tie_first", 32'(cq[0]), 32'd1);
      end

      // req1 write line at 0x2000, data 0x11..0x18.
      do_reset();
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         v1 = (idx < 8); w1 = 1;
         a1 = 32'(32'h2000 + 4*idx); d1 = 32'(32'h11 + idx);
         mful = 1; mld = 32'hFFFF;
         cyc_check("wr");
         if (mv) begin
            check("wr_write", 32'(mw), 32'd1);
            check("wr_data", md, 32'(32'h11 + idx));
         end
         if (f1) idx++;
         advance();
      end
      check("wr_beats", 32'(idx), 32'd8);

      // Memory fulfils every 3rd cycle; req0 drops valid for 2 cycles mid-line.
      do_reset();
      n0 = 0; n1 = 0; gap_left = 0; gap_done = 0;
      for (int c = 0; c < 90; c++) begin
         if (n0 == 3 && gap_done == 0) begin gap_left = 2; gap_done = 1; end
         v0 = (n0 < 8) && (gap_left == 0); a0 = 32'(32'h4000 + 4*n0);
         v1 = (n1 < 8); a1 = 32'(32'h5000 + 4*n1);
         mld = 32'(c);
         mful = (c % 3 == 2) && ((m_owner == 0 && v0) || (m_owner == 1 && v1));
         cyc_check("gap");
         if (gap_left > 0) check("gap_memvalid", 32'(mv), 32'd0);
         if (f1 && n0 < 8) check("gap_early_req1", 32'(f1), 32'd0);
         if (f0) n0++;
         if (f1) n1++;
         advance();
         if (gap_left > 0) gap_left--;
      end
      check("gap_req0_beats", 32'(n0), 32'd8);
      check("gap_req1_beats", 32'(n1), 32'd8);

      // Reset at beat 4 of an OWN0 line, then a fresh req1 line.
      do_reset();
      n0 = 0;
      for (int c = 0; c < 20 && n0 < 4; c++) begin
         v0 = 1; a0 = 32'(32'h6000 + 4*n0); mful = 1; mld = 32'hBEEF;
         cyc_check("rst_mid");
         if (f0) n0++;
         advance();
      end
      check("rst_mid_beats", 32'(n0), 32'd4);
      rst = 1;
      cyc_check("rst_mid_edge");
      advance();
      rst = 0; v0 = 0; v1 = 1; a1 = 32'h7000;
      cyc_check("rst_after");
      check("rst_after_mv", 32'(mv), 32'd0);
      check("rst_after_f1", 32'(f1), 32'd0);
      advance();
      fcount = 0; last_f1 = 1'b1;
      for (int c = 0; c < 9; c++) begin
         cyc_check("rst_req1");
         if (f1) fcount++;
         last_f1 = f1;
         advance();
      end
      check("rst_req1_beats", 32'(fcount), 32'd8);
      check("rst_req1_idle", 32'(last_f1), 32'd0);

      // Random stimulus against the model, including occasional resets.
      for (int c = 0; c < 500; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         v0 = $urandom_range(0, 3) != 0; w0 = $urandom_range(0, 1) != 0;
         a0 = $urandom & 32'hFFFF_FFFC; d0 = $urandom;
         v1 = $urandom_range(0, 3) != 0; w1 = $urandom_range(0, 1) != 0;
         a1 = $urandom & 32'hFFFF_FFFC; d1 = $urandom;
         mld = $urandom; mful = $urandom_range(0, 2) != 0;
         cyc_check("random");
         advance();
      end
      rst = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
